// File: rtl/multicycle_alu.sv
// Multi-cycle ALU: single-cycle logic/arith ops, bit-serial shifts.
// Valid/ready request and result handshakes around a 3-state FSM.
module multicycle_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       Operation,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALUResult,
  output logic             Zero
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLL = 4'b0011;
  localparam logic [3:0] OP_SLT = 4'b1100;
  localparam logic [3:0] OP_XOR = 4'b0100;
  localparam logic [3:0] OP_SRL = 4'b0101;
  localparam logic [3:0] OP_SRA = 4'b1010;
  localparam logic [3:0] OP_BEQ = 4'b1000;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t           state;
  logic [3:0]       op_q;
  logic [4:0]       cnt;
  logic [WIDTH-1:0] comb_res;
  logic [WIDTH-1:0] step_res;
  logic             is_shift;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  assign is_shift = (Operation == OP_SLL) ||
                    (Operation == OP_SRL) ||
                    (Operation == OP_SRA);

  always_comb begin
    comb_res = '0;
    case (Operation)
      OP_AND: comb_res = SrcA & SrcB;
      OP_OR:  comb_res = SrcA | SrcB;
      OP_ADD: comb_res = SrcA + SrcB;
      OP_SUB: comb_res = SrcA - SrcB;
      OP_BEQ: comb_res = SrcA - SrcB;
      OP_XOR: comb_res = SrcA ^ SrcB;
      OP_SLT: comb_res = {{(WIDTH-1){1'b0}},
                          $signed(SrcA) < $signed(SrcB)};
      // zero-amount shifts bypass the SHIFT state
      OP_SLL, OP_SRL, OP_SRA: comb_res = SrcA;
      default: comb_res = '0;
    endcase
  end

  always_comb begin
    step_res = ALUResult;
    case (op_q)
      OP_SLL: step_res = {ALUResult[WIDTH-2:0], 1'b0};
      OP_SRL: step_res = {1'b0, ALUResult[WIDTH-1:1]};
      OP_SRA: step_res = {ALUResult[WIDTH-1],
                          ALUResult[WIDTH-1:1]};
      default: step_res = ALUResult;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      op_q      <= '0;
      cnt       <= '0;
      ALUResult <= '0;
      Zero      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_q <= Operation;
            if (is_shift && SrcB[4:0] != 5'd0) begin
              ALUResult <= SrcA;
              Zero      <= 1'b0;
              cnt       <= SrcB[4:0];
              state     <= SHIFT;
            end else begin
              ALUResult <= comb_res;
              Zero      <= (comb_res == '0);
              state     <= DONE;
            end
          end
        end
        SHIFT: begin
          ALUResult <= step_res;
          cnt       <= cnt - 5'd1;
          // leave on the edge that applies the last bit
          if (cnt == 5'd1) begin
            Zero  <= (step_res == '0);
            state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_alu.sv
// Randomized and directed bench for multicycle_alu against
// an arithmetic reference model.
module tb_multicycle_alu;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  Operation = 4'd0;
  logic [31:0] SrcA = '0;
  logic [31:0] SrcB = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] ALUResult;
  logic        Zero;

  int errors = 0;
  int checks = 0;

  multicycle_alu #(.WIDTH(32)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .Operation(Operation),
    .SrcA(SrcA),
    .SrcB(SrcB),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .ALUResult(ALUResult),
    .Zero(Zero)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_alu(
    input logic [3:0] op, input logic [31:0] a,
    input logic [31:0] b);
    int sh;
    sh = int'(b[4:0]);
    case (op)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b1000: return a - b;
      4'b0100: return a ^ b;
      4'b0011: return a << sh;
      4'b0101: return a >> sh;
      4'b1010: return $unsigned($signed(a) >>> sh);
      4'b1100: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  function automatic int ref_lat(
    input logic [3:0] op, input logic [31:0] b);
    if ((op == 4'b0011 || op == 4'b0101 || op == 4'b1010)
        && b[4:0] != 5'd0)
      return int'(b[4:0]) + 1;
    return 1;
  endfunction

  // Drive one request from IDLE, report latency and result,
  // then release it with out_ready.
  task automatic issue(
    input logic [3:0] op, input logic [31:0] a,
    input logic [31:0] b, output int lat,
    output logic [31:0] res, output logic z);
    @(negedge clk);
    in_valid  = 1'b1;
    Operation = op;
    SrcA      = a;
    SrcB      = b;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    SrcA     = $urandom;
    SrcB     = $urandom;
    lat      = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    res = ALUResult;
    z   = Zero;
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #3;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 ||
        ALUResult !== 32'd0 || Zero !== 1'b0) begin
      errors++;
      $display("FAIL reset: rdy=%b vld=%b res=%h z=%b want 1 0 0 0",
               in_ready, out_valid, ALUResult, Zero);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic check_op(
    input string name, input logic [3:0] op,
    input logic [31:0] a, input logic [31:0] b);
    int lat;
    logic [31:0] res;
    logic z;
    logic [31:0] exp;
    exp = ref_alu(op, a, b);
    issue(op, a, b, lat, res, z);
    checks++;
    if (lat !== ref_lat(op, b) || res !== exp ||
        z !== (exp == 32'd0)) begin
      errors++;
      $display("FAIL %s op=%b a=%h b=%h: lat=%0d res=%h z=%b want lat=%0d res=%h z=%b",
               name, op, a, b, lat, res, z,
               ref_lat(op, b), exp, exp == 32'd0);
    end
  endtask

  task automatic test_directed();
    check_op("add", 4'b0010, 32'h5, 32'h3);
    check_op("branch", 4'b1000, 32'h1234ABCD, 32'h1234ABCD);
    check_op("sub", 4'b0110, 32'h0, 32'h1);
    check_op("sra", 4'b1010, 32'h80000000, 32'd4);
    check_op("srl", 4'b0101, 32'h80000000, 32'd4);
    check_op("sll0", 4'b0011, 32'hDEADBEEF, 32'd0);
    check_op("slt", 4'b1100, 32'hFFFFFFFF, 32'd1);
    check_op("sll31", 4'b0011, 32'h00000003, 32'd31);
    check_op("badop", 4'b1111, 32'h12345678, 32'h1);
  endtask

  task automatic test_random();
    logic [3:0] ops [11];
    logic [31:0] a, b;
    ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0011,
            4'b1100, 4'b0100, 4'b0101, 4'b1010, 4'b1000,
            4'b0111};
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 4) == 0) b = a;
      if ($urandom_range(0, 3) == 0) b = b & 32'h7;
      check_op("random", ops[$urandom_range(0, 10)], a, b);
    end
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    in_valid  = 1'b1;
    Operation = 4'b0010;
    SrcA      = 32'h5;
    SrcB      = 32'h3;
    out_ready = 1'b0;
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
          ALUResult !== 32'h8 || Zero !== 1'b0) begin
        errors++;
        $display("FAIL hold%0d: vld=%b rdy=%b res=%h z=%b want 1 0 00000008 0",
                 i, out_valid, in_ready, ALUResult, Zero);
      end
      @(negedge clk);
      SrcA = 32'h100 + i;
      @(posedge clk);
    end
    @(negedge clk);
    SrcA      = 32'h64;
    SrcB      = 32'h1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL release: vld=%b rdy=%b want 0 1",
               out_valid, in_ready);
    end
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b1 || ALUResult !== 32'h65) begin
      errors++;
      $display("FAIL next_req: vld=%b res=%h want 1 00000065",
               out_valid, ALUResult);
    end
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, b;
    int results = 0;
    int bad = 0;
    a = $urandom;
    b = $urandom;
    @(negedge clk);
    in_valid  = 1'b1;
    Operation = 4'b0100;
    SrcA      = a;
    SrcB      = b;
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        results++;
        if (ALUResult !== (a ^ b) || in_ready) bad++;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checks++;
    if (results != 10 || bad != 0) begin
      errors++;
      $display("FAIL back_to_back: results=%0d bad=%0d want 10 0",
               results, bad);
    end
  endtask

  task automatic test_reset_mid_shift();
    int seen = 0;
    @(negedge clk);
    in_valid  = 1'b1;
    Operation = 4'b0011;
    SrcA      = 32'hFFFFFFFF;
    SrcB      = 32'd31;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (ALUResult !== 32'd0 || Zero !== 1'b0 ||
        out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_rst: res=%h z=%b vld=%b rdy=%b want 0 0 0 1",
               ALUResult, Zero, out_valid, in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    checks++;
    if (seen != 0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL after_rst: valid_cycles=%0d rdy=%b want 0 1",
               seen, in_ready);
    end
    out_ready = 1'b0;
    check_op("post_rst", 4'b0001, 32'hF0F0F0F0, 32'h0F0F0F0F);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_reset_mid_shift();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: sim did not finish");
    $fatal(1);
  end

endmodule
